// File: rtl/descrambler_pkg.sv
// Shared constants and types for the PRBS15 descrambler sync controller.
package descrambler_pkg;

    // PRBS15 polynomial x^15 + x^14 + 1: history length and tap positions
    localparam int PRBS_LEN    = 15;
    localparam int PRBS_TAP_HI = 15;
    localparam int PRBS_TAP_LO = 14;

    // Accepted bits needed to fill descrambler history after reset
    localparam int FLUSH_BITS  = 15;

    typedef enum logic [1:0] {
        FLUSH,
        HUNT,
        CONFIRM,
        LOCKED
    } desc_state_t;

endpackage

// File: rtl/prbs15_descrambler.sv
// Self-synchronising PRBS15 descrambler: shift register of received
// scrambled bits plus the tap XOR. The decoded bit is combinational.
module prbs15_descrambler
    import descrambler_pkg::*;
(
    input  logic clock_in,
    input  logic reset_n,
    input  logic shift_en,
    input  logic data_in,
    output logic decoded
);

    logic [PRBS_LEN-1:0] sr;

    // Keep the last PRBS_LEN received (scrambled) bits
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (shift_en) begin
            sr <= {sr[PRBS_LEN-2:0], data_in};
        end
    end

    assign decoded = data_in ^ sr[PRBS_TAP_HI-1] ^ sr[PRBS_TAP_LO-1];

endmodule

// File: rtl/descrambler_sync_ctrl.sv
// Receive-path sequencer: flushes descrambler history, hunts for the frame
// sync word in the descrambled stream, confirms it over LOCK_HITS frames,
// then tracks lock and flags payload bits and frame starts.
//
// Flow control: a bit is accepted only when enable_in and data_valid_in
// are both high in the same cycle. No state moves on other cycles, and
// decoded_valid_out / frame_start_out are 0 on the output cycle after them.
// All outputs are registered one clock after the accepted input bit.
module descrambler_sync_ctrl
    import descrambler_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD   = 16'hEB90,
    parameter int          SYNC_LEN    = 16,
    parameter int          FRAME_LEN   = 256,
    parameter int          LOCK_HITS   = 2,
    parameter int          LOSS_MISSES = 3
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        enable_in,
    input  logic        data_valid_in,
    input  logic        data_in,
    output logic        decoded_out,
    output logic        decoded_valid_out,
    output logic        frame_start_out,
    output logic        locked_out,
    output logic [15:0] miss_count_out
);

    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int HIT_W  = $clog2(LOCK_HITS + 1);
    localparam int MISS_W = $clog2(LOSS_MISSES + 1);

    localparam logic [CNT_W-1:0]    LAST_BIT   = CNT_W'(FRAME_LEN - 1);
    localparam logic [HIT_W-1:0]    HIT_TARGET = HIT_W'(LOCK_HITS);
    localparam logic [MISS_W-1:0]   MISS_LIMIT = MISS_W'(LOSS_MISSES);
    localparam logic [SYNC_LEN-1:0] SYNC_PAT   = SYNC_WORD[SYNC_LEN-1:0];
    localparam logic [3:0]          FLUSH_LAST = 4'(FLUSH_BITS - 1);

    // FSM state is kept as a named signal so checkers can bind to it
    desc_state_t         state;
    logic                accept;
    logic                d;
    logic                match;
    logic                at_boundary;
    logic [SYNC_LEN-1:0] hunt_reg;
    logic [SYNC_LEN-1:0] hunt_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [3:0]          flush_cnt;
    logic [HIT_W-1:0]    hit_cnt;
    logic [HIT_W-1:0]    hit_inc;
    logic [MISS_W-1:0]   miss_cnt;
    logic [MISS_W-1:0]   miss_inc;

    assign accept = enable_in & data_valid_in;

    prbs15_descrambler u_descrambler (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .shift_en (accept),
        .data_in  (data_in),
        .decoded  (d)
    );

    // Sync comparison looks at the window including the current bit
    assign hunt_next   = SYNC_LEN'({hunt_reg, d});
    assign match       = (hunt_next == SYNC_PAT);
    assign at_boundary = (bit_cnt == LAST_BIT);
    assign hit_inc     = hit_cnt + HIT_W'(1);
    assign miss_inc    = miss_cnt + MISS_W'(1);

    // Sliding window of the most recent descrambled bits
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            hunt_reg <= '0;
        end else if (accept) begin
            hunt_reg <= hunt_next;
        end
    end

    // Sync FSM with counters and registered outputs
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state             <= FLUSH;
            flush_cnt         <= '0;
            bit_cnt           <= '0;
            hit_cnt           <= '0;
            miss_cnt          <= '0;
            decoded_out       <= 1'b0;
            decoded_valid_out <= 1'b0;
            frame_start_out   <= 1'b0;
            locked_out        <= 1'b0;
            miss_count_out    <= '0;
        end else begin
            decoded_valid_out <= 1'b0;
            frame_start_out   <= 1'b0;
            if (accept) begin
                decoded_out <= d;
                case (state)
                    FLUSH: begin
                        if (flush_cnt == FLUSH_LAST) begin
                            state <= HUNT;
                        end else begin
                            flush_cnt <= flush_cnt + 4'd1;
                        end
                    end
                    HUNT: begin
                        if (match) begin
                            bit_cnt <= '0;
                            hit_cnt <= HIT_W'(1);
                            if (LOCK_HITS == 1) begin
                                state             <= LOCKED;
                                locked_out        <= 1'b1;
                                frame_start_out   <= 1'b1;
                                decoded_valid_out <= 1'b1;
                                miss_cnt          <= '0;
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        if (at_boundary) begin
                            bit_cnt <= '0;
                            if (match) begin
                                hit_cnt <= hit_inc;
                                if (hit_inc == HIT_TARGET) begin
                                    state             <= LOCKED;
                                    locked_out        <= 1'b1;
                                    frame_start_out   <= 1'b1;
                                    decoded_valid_out <= 1'b1;
                                    miss_cnt          <= '0;
                                end
                            end else begin
                                // A miss here is not re-tested as a hunt match
                                state   <= HUNT;
                                hit_cnt <= '0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    LOCKED: begin
                        // Every bit of a locked frame is qualified, even the losing boundary bit
                        decoded_valid_out <= 1'b1;
                        if (at_boundary) begin
                            bit_cnt <= '0;
                            if (match) begin
                                frame_start_out <= 1'b1;
                                miss_cnt        <= '0;
                            end else begin
                                miss_cnt <= miss_inc;
                                if (miss_count_out != 16'hFFFF) begin
                                    miss_count_out <= miss_count_out + 16'd1;
                                end
                                if (miss_inc == MISS_LIMIT) begin
                                    state      <= HUNT;
                                    locked_out <= 1'b0;
                                    hit_cnt    <= '0;
                                end
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= FLUSH;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_descrambler_sync_ctrl.sv
// Directed bench for descrambler_sync_ctrl. Frames are EB90 followed by
// 240 payload bits that never contain four zeros in a row, so the sync word
// can only appear where it is placed deliberately. Expected flags per bit
// are given by the caller for each frame segment.
module tb_descrambler_sync_ctrl;

    logic        clock_in = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable_in = 1'b0;
    logic        data_valid_in = 1'b0;
    logic        data_in = 1'b0;
    logic        decoded_out;
    logic        decoded_valid_out;
    logic        frame_start_out;
    logic        locked_out;
    logic [15:0] miss_count_out;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [14:0] scr_sr = '0;
    int          zero_run = 0;
    bit          stall_mode = 1'b0;
    logic        prev_lock = 1'b0;
    logic [15:0] sync_w = 16'hEB90;
    logic [0:0]  exp_q[$];

    descrambler_sync_ctrl dut (
        .clock_in          (clock_in),
        .reset_n           (reset_n),
        .enable_in         (enable_in),
        .data_valid_in     (data_valid_in),
        .data_in           (data_in),
        .decoded_out       (decoded_out),
        .decoded_valid_out (decoded_valid_out),
        .frame_start_out   (frame_start_out),
        .locked_out        (locked_out),
        .miss_count_out    (miss_count_out)
    );

    // Clock
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_decoded"}, {15'd0, decoded_out}, 16'd0);
        check({tag, "_valid"}, {15'd0, decoded_valid_out}, 16'd0);
        check({tag, "_fs"}, {15'd0, frame_start_out}, 16'd0);
        check({tag, "_lock"}, {15'd0, locked_out}, 16'd0);
        check({tag, "_miss"}, miss_count_out, 16'd0);
    endtask

    // Reset DUT and the bench scrambler together
    task automatic do_reset();
        data_valid_in = 1'b0;
        enable_in     = 1'b0;
        reset_n       = 1'b0;
        @(posedge clock_in);
        #1;
        check_idle_outputs("reset");
        reset_n   = 1'b1;
        scr_sr    = '0;
        zero_run  = 0;
        prev_lock = 1'b0;
        exp_q.delete();
    endtask

    // Drive one accepted source bit (scrambled here), optionally preceded by stalls
    task automatic send_bit(input logic src, input logic exp_v, input logic exp_fs, input logic exp_l);
        logic s;
        if (stall_mode) begin
            int n;
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    enable_in     = 1'b0;
                    data_valid_in = 1'($urandom_range(0, 1));
                end else begin
                    enable_in     = 1'b1;
                    data_valid_in = 1'b0;
                end
                data_in = 1'($urandom_range(0, 1));
                @(posedge clock_in);
                #1;
                check("stall_valid", {15'd0, decoded_valid_out}, 16'd0);
                check("stall_fs", {15'd0, frame_start_out}, 16'd0);
                check("stall_lock", {15'd0, locked_out}, {15'd0, prev_lock});
            end
        end
        s      = src ^ scr_sr[14] ^ scr_sr[13];
        scr_sr = {scr_sr[13:0], s};
        exp_q.push_back(src);
        enable_in     = 1'b1;
        data_valid_in = 1'b1;
        data_in       = s;
        @(posedge clock_in);
        #1;
        check("decoded", {15'd0, decoded_out}, {15'd0, exp_q.pop_front()});
        check("valid", {15'd0, decoded_valid_out}, {15'd0, exp_v});
        check("frame_start", {15'd0, frame_start_out}, {15'd0, exp_fs});
        check("locked", {15'd0, locked_out}, {15'd0, exp_l});
        prev_lock = exp_l;
    endtask

    // Payload bits: random, but never four zeros in a row
    task automatic send_payload(input int n, input logic exp_v, input logic exp_l);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            if (zero_run >= 3) b = 1'b1;
            zero_run = b ? 0 : zero_run + 1;
            send_bit(b, exp_v, 1'b0, exp_l);
        end
    endtask

    // Sync word; corrupt flips its last bit. Expectations change on the last bit.
    task automatic send_sync(input logic corrupt, input logic v_pre, input logic v_sync,
                             input logic l_pre, input logic l_post, input logic fs);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b = sync_w[15-i];
            if (i == 15) begin
                if (corrupt) b = ~b;
                send_bit(b, v_sync, fs, l_post);
            end else begin
                send_bit(b, v_pre, 1'b0, l_pre);
            end
        end
        zero_run = corrupt ? 0 : 4;
    endtask

    task automatic send_frame(input logic corrupt, input logic v_pre, input logic v_sync,
                              input logic v_post, input logic l_pre, input logic l_post,
                              input logic fs);
        send_sync(corrupt, v_pre, v_sync, l_pre, l_post, fs);
        send_payload(240, v_post, l_post);
    endtask

    initial begin
        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clock_in);
        #1;
        check_idle_outputs("init");
        reset_n = 1'b1;

        // 1: mid-frame start, lock at second sync boundary
        send_payload(100, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t1_miss", miss_count_out, 16'd0);

        // 2: two misses hold lock; a match clears the run
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("t2_miss2", miss_count_out, 16'd2);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t2_miss4", miss_count_out, 16'd4);

        // 3: three misses drop lock, relock two frames later
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t3_miss7", miss_count_out, 16'd7);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t3_miss_hold", miss_count_out, 16'd7);

        // 4: random stalls from data_valid_in and enable_in
        stall_mode = 1'b1;
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        stall_mode = 1'b0;
        check("t4_miss", miss_count_out, 16'd7);

        // 5: asynchronous reset at bit 100 of a locked frame
        send_sync(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        send_payload(84, 1'b1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("t5_async");
        do_reset();
        send_payload(140, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t5_miss", miss_count_out, 16'd0);

        // 6: lone sync at a false offset never locks
        do_reset();
        send_payload(40, 1'b0, 1'b0);
        send_sync(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_payload(300, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("t6_miss", miss_count_out, 16'd0);

        data_valid_in = 1'b0;
        enable_in     = 1'b0;
        @(posedge clock_in);
        #1;
        check("end_valid", {15'd0, decoded_valid_out}, 16'd0);
        check("end_lock", {15'd0, locked_out}, 16'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
